// File: rtl/fxp_mac_array.sv
// fxp_mac_array: multi-lane signed-weight x unsigned-pixel MAC with frame
// accumulation, final arithmetic shift and saturation to OUT_W bits.
// Three register stages: S1 products, S2 lane sum, S3 accumulate/emit.
// Optional feature macro: FXP_MAC_ROUND_EN (round half up before the shift).
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. The whole pipeline moves
// only when adv = !out_valid || out_ready, so in_ready equals adv and every
// stage, including the output register, holds while adv is low.
module fxp_mac_array #(
  parameter int LANES     = 4,
  parameter int WEIGHT_W  = 19,
  parameter int PIXEL_W   = 10,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 26,
  parameter int OUT_SHIFT = 0
) (
  input  logic                          clk,
  input  logic                          GlobalReset,
  input  logic [LANES*WEIGHT_W-1:0]     WeightPort,
  input  logic [LANES*PIXEL_W-1:0]      PixelPort,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic signed [OUT_W-1:0]       Output_syn,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sat
);

  // Product width keeps the pixel's zero sign bit; the lane sum adds
  // clog2(LANES) guard bits so it can never overflow.
  localparam int P_W = WEIGHT_W + PIXEL_W + 1;
  localparam int S_W = P_W + $clog2(LANES);
  localparam int X_W = ACC_W + 1;

  localparam logic signed [X_W-1:0] ACC_MAX_X = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] ACC_MIN_X = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [X_W-1:0] OUT_MAX_X =
    {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] OUT_MIN_X =
    {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef FXP_MAC_ROUND_EN
  // Half an output LSB; evaluates to zero when OUT_SHIFT is zero.
  localparam logic signed [X_W-1:0] RND = (X_W'(1) << OUT_SHIFT) >> 1;
`else
  localparam logic signed [X_W-1:0] RND = '0;
`endif

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: per-lane products ----------------
  logic signed [P_W-1:0] prod_c [LANES];
  logic signed [P_W-1:0] prod_q [LANES];
  logic                  v1, l1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [P_W-1:0] w_ext;
    logic signed [P_W-1:0] p_ext;
    assign w_ext     = P_W'($signed(WeightPort[i*WEIGHT_W +: WEIGHT_W]));
    assign p_ext     = P_W'({1'b0, PixelPort[i*PIXEL_W +: PIXEL_W]});
    assign prod_c[i] = w_ext * p_ext;
  end

  // S1 register: capture products and beat qualifiers when the pipe advances
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      l1 <= in_valid && in_last;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_c[i];
    end
  end

  // ---------------- S2: lane sum ----------------
  logic signed [S_W-1:0] sum_c;
  logic signed [S_W-1:0] sum_q;
  logic                  v2, l2;

  // Exact sum of the sign-extended lane products
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + S_W'(prod_q[i]);
  end

  // S2 register: lane sum with its qualifiers
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      v2    <= 1'b0;
      l2    <= 1'b0;
      sum_q <= '0;
    end else if (adv) begin
      v2    <= v1;
      l2    <= l1;
      sum_q <= sum_c;
    end
  end

  // ---------------- S3: accumulate, shift, clamp ----------------
  logic signed [ACC_W-1:0] acc;
  logic                    sticky;
  logic signed [X_W-1:0]   acc_wide;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_clamp;
  logic signed [X_W-1:0]   rnd_x;
  logic signed [X_W-1:0]   shifted;
  logic signed [OUT_W-1:0] res_c;
  logic                    res_clamp;

  // Saturating accumulate, then optional rounding, shift and output clamp
  always_comb begin
    acc_wide  = X_W'(acc) + X_W'(sum_q);
    acc_next  = acc_wide[ACC_W-1:0];
    acc_clamp = 1'b0;
    if (acc_wide > ACC_MAX_X) begin
      acc_next  = ACC_MAX_X[ACC_W-1:0];
      acc_clamp = 1'b1;
    end else if (acc_wide < ACC_MIN_X) begin
      acc_next  = ACC_MIN_X[ACC_W-1:0];
      acc_clamp = 1'b1;
    end
    rnd_x     = X_W'(acc_next) + RND;
    shifted   = rnd_x >>> OUT_SHIFT;
    res_c     = shifted[OUT_W-1:0];
    res_clamp = 1'b0;
    if (shifted > OUT_MAX_X) begin
      res_c     = OUT_MAX_X[OUT_W-1:0];
      res_clamp = 1'b1;
    end else if (shifted < OUT_MIN_X) begin
      res_c     = OUT_MIN_X[OUT_W-1:0];
      res_clamp = 1'b1;
    end
  end

  // S3 register: frame accumulator, sticky saturation and the output slot
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      acc        <= '0;
      sticky     <= 1'b0;
      Output_syn <= '0;
      out_sat    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (adv) begin
      out_valid <= v2 && l2;
      if (v2) begin
        if (l2) begin
          Output_syn <= res_c;
          out_sat    <= sticky | acc_clamp | res_clamp;
          acc        <= '0;
          sticky     <= 1'b0;
        end else begin
          acc    <= acc_next;
          sticky <= sticky | acc_clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac_array.sv
// Directed bench for fxp_mac_array: default instance plus an OUT_SHIFT=4
// instance sharing the same stimulus.
module tb_fxp_mac_array;

  localparam int LANES    = 4;
  localparam int WEIGHT_W = 19;
  localparam int PIXEL_W  = 10;
  localparam int OUT_W    = 26;

  logic                      clk;
  logic                      GlobalReset;
  logic [LANES*WEIGHT_W-1:0] WeightPort;
  logic [LANES*PIXEL_W-1:0]  PixelPort;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic signed [OUT_W-1:0]   Output_syn;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sat;

  logic                      sh_in_ready;
  logic signed [OUT_W-1:0]   sh_out;
  logic                      sh_valid;
  logic                      sh_sat;

  int errors = 0;
  int checks = 0;
  int lat;

  fxp_mac_array dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .WeightPort (WeightPort),
    .PixelPort  (PixelPort),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .Output_syn (Output_syn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat)
  );

  fxp_mac_array #(.OUT_SHIFT(4)) dut_sh (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .WeightPort (WeightPort),
    .PixelPort  (PixelPort),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (sh_in_ready),
    .Output_syn (sh_out),
    .out_valid  (sh_valid),
    .out_ready  (out_ready),
    .out_sat    (sh_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // lane 0 only, other lanes zero weight
  task automatic drive(input logic signed [WEIGHT_W-1:0] w0,
                       input logic [PIXEL_W-1:0] p0, input logic last);
    WeightPort = '0;
    PixelPort  = '0;
    WeightPort[WEIGHT_W-1:0] = w0;
    PixelPort[PIXEL_W-1:0]   = p0;
    in_valid = 1'b1;
    in_last  = last;
  endtask

  // present the current beat for one edge, then count edges to out_valid
  task automatic wait_out(output int n);
    tick();
    n = 1;
    idle();
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    GlobalReset = 1'b1;
    out_ready   = 1'b1;
    WeightPort  = '0;
    PixelPort   = '0;
    idle();
    tick();
    tick();

    // reset state
    check("rst_out", Output_syn, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    GlobalReset = 1'b0;

    // single beat -3*222, latency three edges
    drive(-3, 222, 1'b1);
    wait_out(lat);
    check("t1_latency", lat, 3);
    check("t1_out", Output_syn, -666);
    check("t1_sat", out_sat, 0);
    tick();
    check("t1_drain", out_valid, 0);

    // in_last without in_valid does nothing
    in_valid = 1'b0;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign_last", out_valid, 0);
    end
    idle();

    // two-beat frame then single beat frame, back to back
    drive(50, 8, 1'b0);
    tick();
    drive(100, 20, 1'b1);
    tick();
    drive(-1, 198, 1'b1);
    tick();
    idle();
    tick();
    check("t2_valid_a", out_valid, 1);
    check("t2_out_a", Output_syn, 2400);
    tick();
    check("t2_valid_b", out_valid, 1);
    check("t2_out_b", Output_syn, -198);
    tick();
    check("t2_drain", out_valid, 0);

    // output saturation both directions
    drive(262143, 1023, 1'b1);
    tick();
    drive(-262144, 1023, 1'b1);
    tick();
    idle();
    tick();
    check("t3_out_pos", Output_syn, 33554431);
    check("t3_sat_pos", out_sat, 1);
    tick();
    check("t3_out_neg", Output_syn, -33554432);
    check("t3_sat_neg", out_sat, 1);
    tick();
    check("t3_drain", out_valid, 0);

    // all four lanes: 1*10 - 2*20 + 3*30 - 4*40
    WeightPort = {19'(-4), 19'(3), 19'(-2), 19'(1)};
    PixelPort  = {10'd40, 10'd30, 10'd20, 10'd10};
    in_valid   = 1'b1;
    in_last    = 1'b1;
    wait_out(lat);
    check("lanes_latency", lat, 3);
    check("lanes_out", Output_syn, -100);
    tick();

    // backpressure: three frames queue behind a stalled result
    out_ready = 1'b0;
    drive(7, 10, 1'b1);
    tick();
    drive(-5, 4, 1'b1);
    tick();
    drive(3, 3, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_out", Output_syn, 70);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("rel_out_b", Output_syn, -20);
    check("rel_valid_b", out_valid, 1);
    tick();
    check("rel_out_c", Output_syn, 9);
    check("rel_valid_c", out_valid, 1);
    tick();
    check("rel_drain", out_valid, 0);

    // reset mid-frame with a result pending
    out_ready = 1'b0;
    drive(9, 9, 1'b1);
    tick();
    drive(100, 20, 1'b0);
    tick();
    drive(100, 20, 1'b0);
    tick();
    idle();
    check("pre_rst_out", Output_syn, 81);
    GlobalReset = 1'b1;
    #1;
    check("mid_rst_out", Output_syn, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    GlobalReset = 1'b0;
    out_ready   = 1'b1;
    drive(50, 8, 1'b1);
    wait_out(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_out", Output_syn, 400);
    check("post_rst_sat", out_sat, 0);
    tick();

    // OUT_SHIFT=4 instance: +-2408 shifted
    drive(301, 8, 1'b1);
    tick();
    drive(-301, 8, 1'b1);
    tick();
    idle();
    tick();
    check("sh_valid_pos", sh_valid, 1);
`ifdef FXP_MAC_ROUND_EN
    check("sh_out_pos", sh_out, 151);
`else
    check("sh_out_pos", sh_out, 150);
`endif
    check("sh_sat_pos", sh_sat, 0);
    tick();
`ifdef FXP_MAC_ROUND_EN
    check("sh_out_neg", sh_out, -150);
`else
    check("sh_out_neg", sh_out, -151);
`endif
    check("sh_in_ready", sh_in_ready, 1);
    tick();
    check("sh_drain", sh_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
